// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } ctrl_state_e;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ifid_write;
        logic       idex_write;
        logic       exmem_write;
        logic       ifid_flush;
        logic       idex_flush;
        logic       exmem_flush;
        logic       memwb_flush;
        logic [1:0] pc_sel;
    } ctrl_bundle_t;

    function automatic ctrl_bundle_t default_ctrl();
        ctrl_bundle_t c;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        c.idex_write  = 1'b1;
        c.exmem_write = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_flush  = 1'b0;
        c.exmem_flush = 1'b0;
        c.memwb_flush = 1'b0;
        c.pc_sel      = PC_SEL_SEQ;
        return c;
    endfunction

    // Hold everything up to EX/MEM and drain a bubble into MEM/WB.
    function automatic ctrl_bundle_t freeze_ctrl();
        ctrl_bundle_t c;
        c             = default_ctrl();
        c.pc_write    = 1'b0;
        c.ifid_write  = 1'b0;
        c.idex_write  = 1'b0;
        c.exmem_write = 1'b0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM-stage redirects,
// data-memory waits with timeout, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jal,
    input  logic             mem_jalr,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       pc_sel,
    output logic             mem_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e  state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic         mem_err_q, mem_err_d;
    ctrl_bundle_t ctrl;
    logic         stall_inc;
    logic         flush_inc;
    logic         memwait;
    logic         taken;
    logic         loaduse;

    always_comb begin
        memwait = (mem_memread | mem_memwrite) & ~dmem_ready;
        taken   = (mem_branch & mem_zero) | mem_jal | mem_jalr;
        loaduse = ex_memread && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        ctrl       = default_ctrl();
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            RUN: begin
                if (memwait) begin
                    ctrl       = freeze_ctrl();
                    stall_inc  = 1'b1;
                    wait_cnt_d = WC_W'(1);
                    state_d    = MEM_WAIT;
                end else if (taken) begin
                    // Target is loaded at this edge; the three younger instructions are squashed.
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_flush = 1'b1;
                    ctrl.pc_sel      = mem_jalr ? PC_SEL_JALR : PC_SEL_BR;
                    flush_inc        = 1'b1;
                end else if (loaduse) begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                    stall_inc       = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    ctrl       = freeze_ctrl();
                    stall_inc  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            default: begin
                // ERR and the unused encoding both hold the pipeline until reset.
                ctrl      = freeze_ctrl();
                mem_err_d = 1'b1;
                state_d   = ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign idex_write  = ctrl.idex_write;
    assign exmem_write = ctrl.exmem_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign pc_sel      = ctrl.pc_sel;
    assign mem_err     = mem_err_q;
    assign ctrl_state  = state_q;

endmodule
